fifo_wr_sched: RTL and testbench
================================

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port wclk, reset port wrst_n.
REQ-002 The block SHALL have parameter FIFO_WIDTH, default 8, giving the FIFO write-data width in bits.
REQ-003 The block SHALL have parameter LSB_FIRST, default 1: 1 = the 16-bit item is written low byte first; 0 = high byte first.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- wclk  in  1  write-domain clock
- wrst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A (register-file read data) has an item
- a_data  in  FIFO_WIDTH  requester A item
- gnt_a  out  1  one-cycle pulse: A item captured
- req_b  in  1  requester B (ALU result) has an item
- b_data  in  2*FIFO_WIDTH  requester B item, split into two FIFO words
- gnt_b  out  1  one-cycle pulse: B item captured
- wfull  in  1  FIFO full flag, write domain
- winc  out  1  FIFO write enable
- wdata  out  FIFO_WIDTH  FIFO write data
- busy  out  1  scheduler not idle

Function
REQ-005 The FSM SHALL have states IDLE, WR_A, WR_B0 and WR_B1.
REQ-006 In IDLE, when only req_a is high, the next edge SHALL capture a_data into the hold register, go to WR_A, and set gnt_a to 1 for exactly the following cycle.
REQ-007 In IDLE, when only req_b is high, the next edge SHALL capture b_data, go to WR_B0, and set gnt_b to 1 for exactly the following cycle.
REQ-008 When req_a and req_b are both high in IDLE, the block SHALL grant the requester that does not hold the last_gnt flag.
REQ-009 The last_gnt flag SHALL update on every grant to name the requester just granted; after reset it SHALL favour A (A wins the first tie).
REQ-010 req_a/req_b SHALL be sampled only in IDLE; requests in any other state SHALL be ignored, with no capture and no gnt.
REQ-011 A requester SHALL keep req and data stable until it sees its gnt, and SHALL drop or renew them at the edge that ends the gnt cycle.
REQ-012 winc SHALL equal (state is WR_A, WR_B0 or WR_B1) AND NOT wfull; it SHALL be combinational from the registered state and wfull.
REQ-013 wdata SHALL be driven as follows:
- WR_A: the held A item
- WR_B0: the first byte, which is b_data[FIFO_WIDTH-1:0] when LSB_FIRST=1, else the high half
- WR_B1: the other byte
REQ-014 In a write state with wfull=1, the state and hold register SHALL not change, and winc=0 (stall for any number of cycles).
REQ-015 In a write state with wfull=0, the edge SHALL write one word and advance: WR_A -> IDLE, WR_B0 -> WR_B1, WR_B1 -> IDLE.
REQ-016 The two bytes of a B item SHALL always be written back to back, with no A word between them.
REQ-017 An uncontended 8-bit item SHALL reach the FIFO within 2 cycles of req; a 16-bit item within 3 cycles. Maximum rate: one A item per 2 cycles.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 Asserting wrst_n low SHALL immediately give:
- state = IDLE and busy = 0
- winc = 0, gnt_a = 0, gnt_b = 0
- wdata = 0 and hold register = 0
- last_gnt favouring A
REQ-020 Reset during a write state SHALL discard the held item; no partial B byte is written after reset release.
REQ-021 After wrst_n rises, the first grant SHALL be possible at the first wclk edge.

Verification
REQ-022 Single A: req_a=1, a_data=8'h5A, wfull=0 -> gnt_a pulses 1 cycle; next cycle winc=1 with wdata=8'h5A; then IDLE, busy=0.
REQ-023 Single B: req_b=1, b_data=16'hBEEF, LSB_FIRST=1 -> winc on two consecutive cycles with wdata=8'hEF then 8'hBE; with LSB_FIRST=0 -> 8'hBE then 8'hEF.
REQ-024 Contention: req_a and req_b held high continuously -> grants alternate A, B, A, B starting with A; the FIFO sees the word sequence A, B0, B1, A, B0, B1.
REQ-025 Full stall: wfull=1 for 5 cycles while in WR_B1 -> winc=0 and wdata stable throughout; the cycle after wfull falls, winc=1 with the same byte.
REQ-026 Reset mid-item: wrst_n pulsed low in WR_B0 -> winc=0 and busy=0 at once; after release no 8'hBE word is ever written.
REQ-027 Late request: req_a rises while in WR_B0 -> no gnt_a until IDLE is reached; gnt_a comes in the cycle after IDLE.

Source files
------------

// File: rtl/fifo_wr_sched.sv
// -----------------------------------------------------------------------------
// fifo_wr_sched
// Two-requester write scheduler that feeds a single FIFO write port.
//   Requester A supplies one FIFO_WIDTH-bit word per item.
//   Requester B supplies a 2*FIFO_WIDTH-bit item. It is written as two
//   consecutive FIFO words, and no A word is placed between them.
// If both requesters are waiting in IDLE, the one that was not granted last
// wins. After reset, A wins the first tie. The FIFO full flag stalls the
// current write state for as many cycles as it stays high.
//
// Ports
//   wclk, wrst_n      write-domain clock, asynchronous active-low reset
//   req_a, a_data     requester A request and item
//   gnt_a             one-cycle pulse: A item captured
//   req_b, b_data     requester B request and 2-word item
//   gnt_b             one-cycle pulse: B item captured
//   wfull             FIFO full flag
//   winc, wdata       FIFO write enable and write data
//   busy              scheduler not in IDLE
// -----------------------------------------------------------------------------
module fifo_wr_sched #(
  parameter int FIFO_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic                    req_a,
  input  logic [FIFO_WIDTH-1:0]   a_data,
  output logic                    gnt_a,
  input  logic                    req_b,
  input  logic [2*FIFO_WIDTH-1:0] b_data,
  output logic                    gnt_b,
  input  logic                    wfull,
  output logic                    winc,
  output logic [FIFO_WIDTH-1:0]   wdata,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_A  = 2'd1,
    WR_B0 = 2'd2,
    WR_B1 = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [2*FIFO_WIDTH-1:0] hold_q, hold_d;
  // Set when B was granted last. It resets to 1 so that A wins the first tie.
  logic                    last_gnt_b_q, last_gnt_b_d;
  logic                    gnt_a_q, gnt_a_d;
  logic                    gnt_b_q, gnt_b_d;
  logic                    pick_a, pick_b;

  // A request wins unless B is also asking and A was the last one served.
  assign pick_a = req_a && (!req_b || last_gnt_b_q);
  assign pick_b = req_b && (!req_a || !last_gnt_b_q);

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    hold_d       = hold_q;
    last_gnt_b_d = last_gnt_b_q;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Requests are sampled only here, so any request that arrives during a write is held off.
        if (pick_a) begin
          hold_d       = {{FIFO_WIDTH{1'b0}}, a_data};
          state_d      = WR_A;
          gnt_a_d      = 1'b1;
          last_gnt_b_d = 1'b0;
        end else if (pick_b) begin
          hold_d       = b_data;
          state_d      = WR_B0;
          gnt_b_d      = 1'b1;
          last_gnt_b_d = 1'b1;
        end
      end
      WR_A:    if (!wfull) state_d = IDLE;
      WR_B0:   if (!wfull) state_d = WR_B1;
      WR_B1:   if (!wfull) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the hold register is reset as well, so wdata reads 0 during reset and a stale item cannot leak out.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      last_gnt_b_q <= 1'b1;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values from before the edge.
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_gnt_b_q <= last_gnt_b_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
    end
  end

  // The write port is combinational from the registered state, so wfull takes effect in the same cycle.
  always_comb begin
    wdata = '0;
    unique case (state_q)
      WR_A:    wdata = hold_q[FIFO_WIDTH-1:0];
      WR_B0:   wdata = LSB_FIRST ? hold_q[FIFO_WIDTH-1:0] : hold_q[2*FIFO_WIDTH-1:FIFO_WIDTH];
      WR_B1:   wdata = LSB_FIRST ? hold_q[2*FIFO_WIDTH-1:FIFO_WIDTH] : hold_q[FIFO_WIDTH-1:0];
      default: wdata = '0;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign winc  = busy && !wfull;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_sched
// Directed bench for fifo_wr_sched. It uses one instance with LSB_FIRST=1 and
// a second instance with LSB_FIRST=0. Both instances share the clock, reset,
// data and wfull. Each has its own request inputs.
// -----------------------------------------------------------------------------
module tb_fifo_wr_sched;

  localparam int W = 8;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         req_a, req_b, wfull;
  logic [W-1:0] a_data;
  logic [2*W-1:0] b_data;
  logic         gnt_a, gnt_b, winc, busy;
  logic [W-1:0] wdata;

  logic         req_a2, req_b2;
  logic         gnt_a2, gnt_b2, winc2, busy2;
  logic [W-1:0] wdata2;

  int errors = 0;
  int checks = 0;

  always #5 wclk = ~wclk;

  fifo_wr_sched #(.FIFO_WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_a(req_a), .a_data(a_data), .gnt_a(gnt_a),
    .req_b(req_b), .b_data(b_data), .gnt_b(gnt_b),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy)
  );

  fifo_wr_sched #(.FIFO_WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_a(req_a2), .a_data(a_data), .gnt_a(gnt_a2),
    .req_b(req_b2), .b_data(b_data), .gnt_b(gnt_b2),
    .wfull(wfull), .winc(winc2), .wdata(wdata2), .busy(busy2)
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Observed vector is {gnt_a, gnt_b, winc, busy, wdata}.
  task automatic test_reset();
    wrst_n = 1'b0;
    req_a = 1'b1; req_b = 1'b0; wfull = 1'b0; req_a2 = 1'b0; req_b2 = 1'b0;
    a_data = 8'h33; b_data = 16'h0;
    #2;
    checks++;
    if ({gnt_a, gnt_b, winc, busy, wdata} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {gnt_a, gnt_b, winc, busy, wdata}, 12'h000);
    end
    step();  // a request while reset is held must not be granted
    checks++;
    if ({gnt_a, busy, winc} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got gnt_a/busy/winc=%b expected 000", {gnt_a, busy, winc});
    end
    req_a = 1'b0;
    wrst_n = 1'b1;
  endtask

  task automatic test_single_a();
    req_a = 1'b1; a_data = 8'h5A;
    step();
    checks++;
    if ({gnt_a, gnt_b, winc, busy, wdata} !== {4'b1011, 8'h5A}) begin
      errors++;
      $display("FAIL single_a_write: got %h expected %h", {gnt_a, gnt_b, winc, busy, wdata}, {4'b1011, 8'h5A});
    end
    req_a = 1'b0; a_data = 8'h00;
    step();
    checks++;
    if ({gnt_a, winc, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_a_idle: got gnt_a/winc/busy=%b expected 000", {gnt_a, winc, busy});
    end
  endtask

  task automatic test_single_b();
    req_b = 1'b1; req_b2 = 1'b1; b_data = 16'hBEEF;
    step();
    checks++;
    if ({gnt_b, winc, wdata} !== {2'b11, 8'hEF}) begin
      errors++;
      $display("FAIL single_b_lsb0: got gnt_b/winc/wdata=%h expected %h", {gnt_b, winc, wdata}, {2'b11, 8'hEF});
    end
    checks++;
    if ({gnt_b2, winc2, wdata2} !== {2'b11, 8'hBE}) begin
      errors++;
      $display("FAIL single_b_msb0: got gnt_b/winc/wdata=%h expected %h", {gnt_b2, winc2, wdata2}, {2'b11, 8'hBE});
    end
    req_b = 1'b0; req_b2 = 1'b0; b_data = 16'h0000;
    step();
    checks++;
    if ({gnt_b, winc, wdata} !== {2'b01, 8'hBE}) begin
      errors++;
      $display("FAIL single_b_lsb1: got gnt_b/winc/wdata=%h expected %h", {gnt_b, winc, wdata}, {2'b01, 8'hBE});
    end
    checks++;
    if ({gnt_b2, winc2, wdata2} !== {2'b01, 8'hEF}) begin
      errors++;
      $display("FAIL single_b_msb1: got gnt_b/winc/wdata=%h expected %h", {gnt_b2, winc2, wdata2}, {2'b01, 8'hEF});
    end
    step();
    checks++;
    if ({winc, busy, winc2, busy2} !== 4'b0000) begin
      errors++;
      $display("FAIL single_b_idle: got winc/busy/winc2/busy2=%b expected 0000", {winc, busy, winc2, busy2});
    end
  endtask

  // Both requests stay high, and each requester renews its data when it sees its grant.
  task automatic test_contention();
    logic [11:0] exp_v [9];
    exp_v[0] = {4'b1011, 8'h11};  // grant A, write A
    exp_v[1] = {4'b0000, 8'h00};  // IDLE
    exp_v[2] = {4'b0111, 8'h33};  // grant B, write B0
    exp_v[3] = {4'b0011, 8'h22};  // write B1
    exp_v[4] = {4'b0000, 8'h00};  // IDLE
    exp_v[5] = {4'b1011, 8'h44};  // grant A
    exp_v[6] = {4'b0000, 8'h00};
    exp_v[7] = {4'b0111, 8'h66};  // grant B
    exp_v[8] = {4'b0011, 8'h55};
    wrst_n = 1'b0; #2; wrst_n = 1'b1;  // fresh reset: A must win the first tie
    req_a = 1'b1; a_data = 8'h11;
    req_b = 1'b1; b_data = 16'h2233;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if ({gnt_a, gnt_b, winc, busy, wdata} !== exp_v[i]) begin
        errors++;
        $display("FAIL contention_cyc%0d: got %h expected %h", i, {gnt_a, gnt_b, winc, busy, wdata}, exp_v[i]);
      end
      if (gnt_a) a_data = 8'h44;
      if (gnt_b) b_data = 16'h5566;
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
  endtask

  task automatic test_full_stall();
    req_b = 1'b1; b_data = 16'hBEEF;
    step();  // WR_B0 with wfull low, so EF is written at the next edge
    req_b = 1'b0;
    step();  // WR_B1
    wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({winc, busy, wdata} !== {2'b01, 8'hBE}) begin
        errors++;
        $display("FAIL stall_cyc%0d: got winc/busy/wdata=%h expected %h", i, {winc, busy, wdata}, {2'b01, 8'hBE});
      end
      if (i < 4) step();
    end
    step();
    wfull = 1'b0;
    #1;
    checks++;
    if ({winc, wdata} !== {1'b1, 8'hBE}) begin
      errors++;
      $display("FAIL stall_release: got winc/wdata=%h expected %h", {winc, wdata}, {1'b1, 8'hBE});
    end
    step();
    checks++;
    if ({winc, busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_done: got winc/busy=%b expected 00", {winc, busy});
    end
  endtask

  task automatic test_reset_mid();
    req_b = 1'b1; b_data = 16'hBEEF;
    step();  // WR_B0
    req_b = 1'b0;
    checks++;
    if ({winc, wdata} !== {1'b1, 8'hEF}) begin
      errors++;
      $display("FAIL rstmid_b0: got winc/wdata=%h expected %h", {winc, wdata}, {1'b1, 8'hEF});
    end
    wrst_n = 1'b0;
    #1;
    checks++;
    if ({winc, busy, gnt_b, wdata} !== 11'h000) begin
      errors++;
      $display("FAIL rstmid_now: got winc/busy/gnt_b/wdata=%h expected 000", {winc, busy, gnt_b, wdata});
    end
    #1;
    wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (winc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after%0d: got winc=%b busy=%b wdata=%h expected winc=0 busy=0", i, winc, busy, wdata);
      end
    end
  endtask

  task automatic test_late_req();
    logic [11:0] exp_v [5];
    exp_v[0] = {4'b0111, 8'hEF};  // grant B, WR_B0
    exp_v[1] = {4'b0011, 8'hBE};  // WR_B1, A waits
    exp_v[2] = {4'b0000, 8'h00};  // IDLE
    exp_v[3] = {4'b1011, 8'h77};  // grant A
    exp_v[4] = {4'b0000, 8'h00};
    req_b = 1'b1; b_data = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        req_b = 1'b0;
        req_a = 1'b1; a_data = 8'h77;  // request arrives during WR_B0
      end
      if (i == 3) req_a = 1'b0;
      checks++;
      if ({gnt_a, gnt_b, winc, busy, wdata} !== exp_v[i]) begin
        errors++;
        $display("FAIL late_req_cyc%0d: got %h expected %h", i, {gnt_a, gnt_b, winc, busy, wdata}, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_single_b();
    test_contention();
    test_full_stall();
    test_reset_mid();
    test_late_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
